// File: rtl/prio_encoder_reg.sv
// Registered N-to-log2(N) priority encoder with valid/ready handshake.
// Flags empty/multi-hot codes and keeps a saturating error count.
module prio_encoder_reg #(
  parameter int N     = 4,
  parameter int W     = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     I,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out,
  output logic             out_none,
  output logic             out_multi,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt
);

  logic             vld_q, vld_d;
  logic [W-1:0]     idx_q, idx_d;
  logic             none_q, none_d;
  logic             multi_q, multi_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic         enc_seen;
  logic         enc_multi;
  logic [W-1:0] enc_idx;
  logic         accept;

  // Scan upward so the highest set bit is the last one to claim the index.
  always_comb begin
    enc_seen  = 1'b0;
    enc_multi = 1'b0;
    enc_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (I[k]) begin
        if (enc_seen) enc_multi = 1'b1;
        enc_seen = 1'b1;
        enc_idx  = W'(k);
      end
    end
  end

  assign in_ready = rst_n && (!vld_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Next-state for result, valid flag and saturating error counter.
  always_comb begin
    vld_d   = vld_q;
    idx_d   = idx_q;
    none_d  = none_q;
    multi_d = multi_q;
    cnt_d   = cnt_q;
    if (accept) begin
      vld_d   = 1'b1;
      idx_d   = enc_idx;
      none_d  = !enc_seen;
      multi_d = enc_multi;
    end else if (vld_q && out_ready) begin
      vld_d = 1'b0;
    end
    if (err_clr) begin
      cnt_d = '0;
    end else if (accept && (!enc_seen || enc_multi)
                 && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= 1'b0;
      idx_q   <= '0;
      none_q  <= 1'b0;
      multi_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      vld_q   <= vld_d;
      idx_q   <= idx_d;
      none_q  <= none_d;
      multi_q <= multi_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = vld_q;
  assign out       = idx_q;
  assign out_none  = none_q;
  assign out_multi = multi_q;
  assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_prio_encoder_reg.sv
// Directed testbench for prio_encoder_reg (N=4).
// Immediate assertions at each check point.
module tb_prio_encoder_reg;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] I;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out;
  logic       out_none;
  logic       out_multi;
  logic       err_clr;
  logic [7:0] err_cnt;

  int checks;
  int failures;

  prio_encoder_reg #(.N(4), .W(2), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .I         (I),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_none  (out_none),
    .out_multi (out_multi),
    .err_clr   (err_clr),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_res(input string tag,
                         input logic [1:0] e_out,
                         input logic e_none,
                         input logic e_multi,
                         input logic [7:0] e_cnt);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_out"}, 32'(out), 32'(e_out));
    chk({tag, "_none"}, 32'(out_none), 32'(e_none));
    chk({tag, "_multi"}, 32'(out_multi), 32'(e_multi));
    chk({tag, "_cnt"}, 32'(err_cnt), 32'(e_cnt));
  endtask

  logic [1:0] exp_s;

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    I         = 4'b0000;
    err_clr   = 1'b0;

    #3;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_none", 32'(out_none), 32'd0);
    chk("rst_multi", 32'(out_multi), 32'd0);
    chk("rst_cnt", 32'(err_cnt), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);

    step();
    rst_n = 1'b1;
    step();
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_ready", 32'(in_ready), 32'd1);

    // one-hot accepts
    in_valid = 1'b1; I = 4'b0001; step();
    chk_res("oh0", 2'd0, 1'b0, 1'b0, 8'd0);
    I = 4'b0010; step();
    chk_res("oh1", 2'd1, 1'b0, 1'b0, 8'd0);
    I = 4'b0100; step();
    chk_res("oh2", 2'd2, 1'b0, 1'b0, 8'd0);
    I = 4'b1000; step();
    chk_res("oh3", 2'd3, 1'b0, 1'b0, 8'd0);
    in_valid = 1'b0; I = 4'b0110; step();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_cnt", 32'(err_cnt), 32'd0);

    // invalid codes
    in_valid = 1'b1; I = 4'b0000; step();
    chk_res("none", 2'd0, 1'b1, 1'b0, 8'd1);
    I = 4'b0110; step();
    chk_res("m0110", 2'd2, 1'b0, 1'b1, 8'd2);
    I = 4'b1111; step();
    chk_res("m1111", 2'd3, 1'b0, 1'b1, 8'd3);
    in_valid = 1'b0; step();
    chk("drain2_valid", 32'(out_valid), 32'd0);
    chk("drain2_cnt", 32'(err_cnt), 32'd3);

    // back-pressure
    out_ready = 1'b0; in_valid = 1'b1; I = 4'b0100; step();
    chk_res("bp_acc", 2'd2, 1'b0, 1'b0, 8'd3);
    chk("bp_ready", 32'(in_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      I = c[0] ? 4'b0001 : 4'b1111;
      step();
      chk_res("bp_hold", 2'd2, 1'b0, 1'b0, 8'd3);
      chk("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1; I = 4'b0001; #1;
    chk("bp_rel_ready", 32'(in_ready), 32'd1);
    step();
    chk_res("bp_rel", 2'd0, 1'b0, 1'b0, 8'd3);

    // streaming, alternating 1000/0001
    for (int c = 0; c < 8; c++) begin
      I = c[0] ? 4'b0001 : 4'b1000;
      exp_s = c[0] ? 2'd0 : 2'd3;
      step();
      chk_res("stream", exp_s, 1'b0, 1'b0, 8'd3);
      chk("stream_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0; step();

    // saturation
    in_valid = 1'b1; I = 4'b0000;
    for (int c = 0; c < 300; c++) step();
    chk("sat_cnt", 32'(err_cnt), 32'd255);
    step(); step();
    chk("sat_hold", 32'(err_cnt), 32'd255);
    err_clr = 1'b1; step();
    chk("clr_wins", 32'(err_cnt), 32'd0);
    err_clr = 1'b0; step();
    chk("after_clr", 32'(err_cnt), 32'd1);

    // build up out=3, err_cnt=5
    I = 4'b1100;
    for (int c = 0; c < 4; c++) step();
    chk_res("pre_rst", 2'd3, 1'b0, 1'b1, 8'd5);

    // asynchronous reset between edges
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_out", 32'(out), 32'd0);
    chk("arst_multi", 32'(out_multi), 32'd0);
    chk("arst_cnt", 32'(err_cnt), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd0);
    step();
    rst_n = 1'b1;
    in_valid = 1'b1; I = 4'b0010; step();
    chk_res("post_rst", 2'd1, 1'b0, 1'b0, 8'd0);
    in_valid = 1'b0; step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
